// File: rtl/insertion_ctrl_if.sv
// Signal bundle between the insertion sequencer, the image/watermark RAMs and the
// insertion datapath. The sequencer is the master; the surrounding memories are the slave.
interface insertion_ctrl_if #(
   parameter int ADDR_W = 12
);
   logic              start;
   logic [7:0]        a1_cfg;
   logic [7:0]        a2_cfg;
   logic              busy;
   logic              done;
   logic              pix_rd_en;
   logic [ADDR_W-1:0] pix_rd_addr;
   logic [7:0]        pix_rd_data;
   logic              wm_rd_en;
   logic [ADDR_W-1:0] wm_rd_addr;
   logic [1:0]        wm_rd_data;
   logic [7:0]        dp_data1;
   logic [7:0]        dp_data2;
   logic [7:0]        dp_data3;
   logic [7:0]        dp_data4;
   logic [7:0]        dp_a1;
   logic [7:0]        dp_a2;
   logic [1:0]        dp_wm;
   logic [7:0]        dp_result;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (
      input  start, a1_cfg, a2_cfg, pix_rd_data, wm_rd_data, dp_result,
      output busy, done, pix_rd_en, pix_rd_addr, wm_rd_en, wm_rd_addr,
             dp_data1, dp_data2, dp_data3, dp_data4, dp_a1, dp_a2, dp_wm,
             wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, a1_cfg, a2_cfg, pix_rd_data, wm_rd_data, dp_result,
      input  busy, done, pix_rd_en, pix_rd_addr, wm_rd_en, wm_rd_addr,
             dp_data1, dp_data2, dp_data3, dp_data4, dp_a1, dp_a2, dp_wm,
             wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/insertion_ctrl.sv
// Frame sequencer for watermark insertion: walks the cover image in raster order, fetches each
// clamped 2x2 neighbourhood plus watermark symbol, runs the datapath and writes the result.
module insertion_ctrl #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   insertion_ctrl_if.master bus
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [ADDR_W-1:0] LAST_P   = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPT,
      S_EXEC,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            r_state, w_stateNxt;
   logic [1:0]        r_k, w_kNxt;
   logic [COL_W-1:0]  r_col, w_colNxt;
   logic [ROW_W-1:0]  r_row, w_rowNxt;
   logic [ADDR_W-1:0] r_p, w_pNxt;

   logic              r_busy, w_busyNxt;
   logic              r_done, w_doneNxt;
   logic              r_pixRdEn, w_pixRdEnNxt;
   logic [ADDR_W-1:0] r_pixRdAddr, w_pixRdAddrNxt;
   logic              r_wmRdEn, w_wmRdEnNxt;
   logic [ADDR_W-1:0] r_wmRdAddr, w_wmRdAddrNxt;
   logic [7:0]        r_data1, w_data1Nxt;
   logic [7:0]        r_data2, w_data2Nxt;
   logic [7:0]        r_data3, w_data3Nxt;
   logic [7:0]        r_data4, w_data4Nxt;
   logic [7:0]        r_a1, w_a1Nxt;
   logic [7:0]        r_a2, w_a2Nxt;
   logic [1:0]        r_wm, w_wmNxt;
   logic              r_wrEn, w_wrEnNxt;
   logic [ADDR_W-1:0] r_wrAddr, w_wrAddrNxt;
   logic [7:0]        r_wrData, w_wrDataNxt;

   logic [ADDR_W-1:0] w_dc;
   logic [ADDR_W-1:0] w_dr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_p         <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pixRdEn   <= 1'b0;
         r_pixRdAddr <= '0;
         r_wmRdEn    <= 1'b0;
         r_wmRdAddr  <= '0;
         r_data1     <= '0;
         r_data2     <= '0;
         r_data3     <= '0;
         r_data4     <= '0;
         r_a1        <= '0;
         r_a2        <= '0;
         r_wm        <= '0;
         r_wrEn      <= 1'b0;
         r_wrAddr    <= '0;
         r_wrData    <= '0;
      end else begin
         r_state     <= w_stateNxt;
         r_k         <= w_kNxt;
         r_col       <= w_colNxt;
         r_row       <= w_rowNxt;
         r_p         <= w_pNxt;
         r_busy      <= w_busyNxt;
         r_done      <= w_doneNxt;
         r_pixRdEn   <= w_pixRdEnNxt;
         r_pixRdAddr <= w_pixRdAddrNxt;
         r_wmRdEn    <= w_wmRdEnNxt;
         r_wmRdAddr  <= w_wmRdAddrNxt;
         r_data1     <= w_data1Nxt;
         r_data2     <= w_data2Nxt;
         r_data3     <= w_data3Nxt;
         r_data4     <= w_data4Nxt;
         r_a1        <= w_a1Nxt;
         r_a2        <= w_a2Nxt;
         r_wm        <= w_wmNxt;
         r_wrEn      <= w_wrEnNxt;
         r_wrAddr    <= w_wrAddrNxt;
         r_wrData    <= w_wrDataNxt;
      end
   end

   always_comb begin
      w_stateNxt     = r_state;
      w_kNxt         = r_k;
      w_colNxt       = r_col;
      w_rowNxt       = r_row;
      w_pNxt         = r_p;
      w_pixRdAddrNxt = r_pixRdAddr;
      w_wmRdAddrNxt  = r_wmRdAddr;
      w_data1Nxt     = r_data1;
      w_data2Nxt     = r_data2;
      w_data3Nxt     = r_data3;
      w_data4Nxt     = r_data4;
      w_a1Nxt        = r_a1;
      w_a2Nxt        = r_a2;
      w_wmNxt        = r_wm;
      w_wrAddrNxt    = r_wrAddr;
      w_wrDataNxt    = r_wrData;
      w_pixRdEnNxt   = 1'b0;
      w_wmRdEnNxt    = 1'b0;
      w_wrEnNxt      = 1'b0;
      w_doneNxt      = 1'b0;
      w_busyNxt      = 1'b0;
      w_dc           = '0;
      w_dr           = '0;

      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_a1Nxt    = bus.a1_cfg;
               w_a2Nxt    = bus.a2_cfg;
               w_colNxt   = '0;
               w_rowNxt   = '0;
               w_pNxt     = '0;
               w_kNxt     = 2'd0;
               w_stateNxt = S_FETCH;
            end
         end
         S_FETCH: begin
            // Read data returned this cycle belongs to the strobe issued at k-1.
            case (r_k)
               2'd1: begin
                  w_data1Nxt = bus.pix_rd_data;
                  w_wmNxt    = bus.wm_rd_data;
               end
               2'd2:    w_data2Nxt = bus.pix_rd_data;
               2'd3:    w_data3Nxt = bus.pix_rd_data;
               default: ;
            endcase
            if (r_k == 2'd3) begin
               w_stateNxt = S_CAPT;
            end else begin
               w_kNxt = r_k + 2'd1;
            end
         end
         S_CAPT: begin
            w_data4Nxt = bus.pix_rd_data;
            w_stateNxt = S_EXEC;
         end
         S_EXEC: begin
            w_wrDataNxt = bus.dp_result;
            w_wrAddrNxt = r_p;
            w_stateNxt  = S_WRITE;
         end
         S_WRITE: begin
            if (r_p == LAST_P) begin
               w_stateNxt = S_DONE;
            end else begin
               w_pNxt = r_p + ADDR_W'(1);
               if (r_col == LAST_COL) begin
                  w_colNxt = '0;
                  w_rowNxt = r_row + ROW_W'(1);
               end else begin
                  w_colNxt = r_col + COL_W'(1);
               end
               w_kNxt     = 2'd0;
               w_stateNxt = S_FETCH;
            end
         end
         S_DONE: begin
            w_stateNxt = S_IDLE;
         end
         default: begin
            w_stateNxt = S_IDLE;
         end
      endcase

      // Registered outputs follow the state being entered, so they line up with that state's cycle.
      w_dc      = (w_colNxt == LAST_COL) ? '0 : ADDR_W'(1);
      w_dr      = (w_rowNxt == LAST_ROW) ? '0 : ADDR_W'(IMG_W);
      w_busyNxt = (w_stateNxt != S_IDLE);
      w_doneNxt = (w_stateNxt == S_DONE);
      w_wrEnNxt = (w_stateNxt == S_WRITE);
      if (w_stateNxt == S_FETCH) begin
         w_pixRdEnNxt = 1'b1;
         case (w_kNxt)
            2'd0:    w_pixRdAddrNxt = w_pNxt;
            2'd1:    w_pixRdAddrNxt = w_pNxt + w_dc;
            2'd2:    w_pixRdAddrNxt = w_pNxt + w_dr;
            default: w_pixRdAddrNxt = w_pNxt + w_dr + w_dc;
         endcase
         if (w_kNxt == 2'd0) begin
            w_wmRdEnNxt   = 1'b1;
            w_wmRdAddrNxt = w_pNxt;
         end
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.pix_rd_en   = r_pixRdEn;
   assign bus.pix_rd_addr = r_pixRdAddr;
   assign bus.wm_rd_en    = r_wmRdEn;
   assign bus.wm_rd_addr  = r_wmRdAddr;
   assign bus.dp_data1    = r_data1;
   assign bus.dp_data2    = r_data2;
   assign bus.dp_data3    = r_data3;
   assign bus.dp_data4    = r_data4;
   assign bus.dp_a1       = r_a1;
   assign bus.dp_a2       = r_a2;
   assign bus.dp_wm       = r_wm;
   assign bus.wr_en       = r_wrEn;
   assign bus.wr_addr     = r_wrAddr;
   assign bus.wr_data     = r_wrData;
endmodule
